mipi_tx_framer: RTL and testbench



---
 rtl/mipi_tx_framer.sv | 196 +++++++++++++++++++
 tb/tb_mipi_tx_framer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_tx_framer.sv
// mipi_tx_framer: transmit-side packet framer for the MIPI TX pixel path.
// Emits marker preamble, header, payload and (optionally) a checksum trailer
// as 48-bit words in the low bits of pixel_value, advancing on pixel_en.
// Optional feature macro: MIPI_TX_FRAMER_CHECKSUM_EN (adds TRAILER + accumulator).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no frame; waits for data_available, pixel_value = 0
// S_PREAMBLE | sending PREAMBLE_WORDS marker words (48'h7e7e7e7e7e7e)
// S_HEADER   | sending {16'h5A5A, seq, DLEN[15:0]}
// S_PAYLOAD  | sending NWORDS payload words, 6 bytes each, zero padded
// S_TRAILER  | sending {32'h0, checksum} (checksum build only)

module mipi_tx_framer #(
    parameter int DLEN           = 512,
    parameter int PREAMBLE_WORDS = 2
) (
    input  logic                tx_pixel_clk,
    input  logic                rst_n,
    input  logic [DLEN*8-1:0]   pix_gen_data,
    input  logic                data_available,
    input  logic                pixel_en,
    output logic                busy,
    output logic                frame_done,
    output logic [63:0]         pixel_value
);

    localparam int NWORDS = (DLEN + 5) / 6;
    localparam int SH_W   = NWORDS * 48;
    localparam int IDX_W  = $clog2(NWORDS + 1);
    localparam int PRE_W  = $clog2(PREAMBLE_WORDS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PREAMBLE_WORDS - 1);
    localparam logic [15:0]      DLEN16   = 16'(DLEN);
    localparam logic [47:0]      MARKER   = 48'h7e7e7e7e7e7e;

`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TRAILER
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic               frame_end;
    logic [SH_W-1:0]    shadow_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic [PRE_W-1:0]   pre_cnt_q;
    logic [15:0]        seq_q;
    logic [47:0]        payload_word;

    // Shadow is zero-extended at latch time, so pad bytes of the last word read as 0.
    assign payload_word = shadow_q[int'(word_idx_q) * 48 +: 48];
    assign busy         = (state_q != S_IDLE);

`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
    logic [15:0] csum_q;

    function automatic logic [15:0] word_sum(input logic [47:0] w);
        logic [15:0] s;
        s = 16'h0;
        for (int j = 0; j < 6; j++) begin
            s = s + {8'h00, w[8*j +: 8]};
        end
        return s;
    endfunction
`endif

    // State register; reset aborts any frame in progress.
    always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every non-idle word is held until pixel_en consumes it.
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_available) begin
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (pixel_en && (pre_cnt_q == LAST_PRE)) begin
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (pixel_en) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (pixel_en && (word_idx_q == LAST_IDX)) begin
`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
                    state_d = S_TRAILER;
`else
                    state_d   = S_IDLE;
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
            S_TRAILER: begin
                if (pixel_en) begin
                    state_d   = S_IDLE;
                    frame_end = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: payload shadow, word/preamble counters, sequence number, done pulse.
    always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            word_idx_q <= '0;
            pre_cnt_q  <= '0;
            seq_q      <= 16'h0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            case (state_q)
                S_IDLE: begin
                    if (data_available) begin
                        shadow_q   <= SH_W'(pix_gen_data);
                        pre_cnt_q  <= '0;
                        word_idx_q <= '0;
                    end
                end
                S_PREAMBLE: begin
                    if (pixel_en) begin
                        pre_cnt_q <= pre_cnt_q + 1'b1;
                    end
                end
                S_HEADER: begin
                    if (pixel_en) begin
                        word_idx_q <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (pixel_en) begin
                        word_idx_q <= word_idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (frame_end) begin
                seq_q <= seq_q + 16'h1;
            end
        end
    end

`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
    // Checksum accumulates each consumed payload word and clears at frame end.
    always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 16'h0;
        end else if (frame_end) begin
            csum_q <= 16'h0;
        end else if ((state_q == S_PAYLOAD) && pixel_en) begin
            csum_q <= csum_q + word_sum(payload_word);
        end
    end
`endif

    // Output word decoded purely from registered state, index and shadow.
    always_comb begin
        pixel_value = 64'h0;
        case (state_q)
            S_PREAMBLE: pixel_value = {16'h0, MARKER};
            S_HEADER:   pixel_value = {16'h0, 16'h5A5A, seq_q, DLEN16};
            S_PAYLOAD:  pixel_value = {16'h0, payload_word};
`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
            S_TRAILER:  pixel_value = {16'h0, 32'h0, csum_q};
`endif
            default:    pixel_value = 64'h0;
        endcase
    end

endmodule

// File: tb/tb_mipi_tx_framer.sv
// Testbench for mipi_tx_framer (DLEN=8, PREAMBLE_WORDS=2).
// A queue-based frame model predicts busy, frame_done and pixel_value each cycle.
// Honours MIPI_TX_FRAMER_CHECKSUM_EN the same way as the design.

module tb_mipi_tx_framer;

    localparam int DLEN = 8;
    localparam int PW   = 2;
    localparam int NW   = (DLEN + 5) / 6;

    logic        tx_pixel_clk = 1'b0;
    logic        rst_n        = 1'b0;
    logic [63:0] pix_gen_data = 64'h0;
    logic        data_available = 1'b0;
    logic        pixel_en     = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [63:0] pixel_value;

    mipi_tx_framer #(.DLEN(DLEN), .PREAMBLE_WORDS(PW)) dut (
        .tx_pixel_clk   (tx_pixel_clk),
        .rst_n          (rst_n),
        .pix_gen_data   (pix_gen_data),
        .data_available (data_available),
        .pixel_en       (pixel_en),
        .busy           (busy),
        .frame_done     (frame_done),
        .pixel_value    (pixel_value)
    );

    always #5 tx_pixel_clk = ~tx_pixel_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of the words still to be sent in the current frame.
    logic [47:0] exp_q[$];
    logic [63:0] obs_q[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_seq  = 16'h0;

    function automatic void build_frame(input logic [63:0] d);
        logic [47:0] w;
        logic [15:0] sum;
        sum = 16'h0;
        exp_q.delete();
        for (int p = 0; p < PW; p++) exp_q.push_back(48'h7e7e7e7e7e7e);
        exp_q.push_back({16'h5A5A, m_seq, 16'(DLEN)});
        for (int i = 0; i < NW; i++) begin
            w = 48'h0;
            for (int j = 0; j < 6; j++) begin
                if (6*i + j < DLEN) begin
                    w[8*j +: 8] = d[8*(6*i + j) +: 8];
                    sum = sum + 16'(d[8*(6*i + j) +: 8]);
                end
            end
            exp_q.push_back(w);
        end
`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
        exp_q.push_back({32'h0, sum});
`endif
    endfunction

    function automatic void model_update();
        m_done = 1'b0;
        if (!m_busy) begin
            if (data_available) begin
                build_frame(pix_gen_data);
                m_busy = 1'b1;
            end
        end else if (pixel_en) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_seq  = m_seq + 16'h1;
            end
        end
    endfunction

    task automatic compare_outputs();
        check("busy", 64'(busy), 64'(m_busy));
        check("frame_done", 64'(frame_done), 64'(m_done));
        check("pixel_value", pixel_value, m_busy ? {16'h0, exp_q[0]} : 64'h0);
    endtask

    // One clock: record a consumed word, let the edge happen, then compare at negedge.
    task automatic step();
        if (pixel_en && busy) obs_q.push_back(pixel_value);
        @(posedge tx_pixel_clk);
        model_update();
        @(negedge tx_pixel_clk);
        compare_outputs();
    endtask

    task automatic run_to_done(input string tag);
        int i;
        for (i = 0; i < 60 && !m_done; i++) step();
        if (!m_done) check({tag, "_timeout"}, 64'(i), 64'd0);
    endtask

    // Literal word list of the 01..08 frame, with the header's sequence number.
    task automatic check_frame_words(input string tag, input logic [15:0] s);
        logic [63:0] lit[$];
        int n;
        lit = '{64'h00007e7e7e7e7e7e, 64'h00007e7e7e7e7e7e,
                {16'h0, 16'h5A5A, s, 16'h0008},
                64'h0000060504030201, 64'h0000000000000807};
`ifdef MIPI_TX_FRAMER_CHECKSUM_EN
        lit.push_back(64'h0000000000000024);
`endif
        check({tag, "_len"}, 64'(obs_q.size()), 64'(lit.size()));
        n = (obs_q.size() < lit.size()) ? obs_q.size() : lit.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), obs_q[i], lit[i]);
        obs_q.delete();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_pixel", pixel_value, 64'h0);
        exp_q.delete();
        obs_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_seq  = 16'h0;
        data_available = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int idle_run;
        int n_done;
        bit seen_busy;
        logic [15:0] seq0;

        // Reset state
        repeat (3) @(negedge tx_pixel_clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(frame_done), 64'd0);
        check("reset_pixel", pixel_value, 64'h0);
        rst_n = 1'b1;
        step();

        // Basic frame, pixel_en always high
        pix_gen_data = 64'h0807060504030201;
        data_available = 1'b1;
        pixel_en = 1'b1;
        step();
        data_available = 1'b0;
        run_to_done("basic");
        step();
        check_frame_words("basic", 16'h0000);

        // Stall for 5 cycles on the first payload word
        data_available = 1'b1;
        step();
        data_available = 1'b0;
        pixel_en = 1'b1;
        repeat (3) step();
        pixel_en = 1'b0;
        repeat (5) step();
        pixel_en = 1'b1;
        run_to_done("stall");
        step();
        check_frame_words("stall", 16'h0001);

        // data_available during payload must be ignored
        data_available = 1'b1;
        step();
        data_available = 1'b0;
        repeat (3) step();
        pix_gen_data = 64'hFFFFFFFFFFFFFFFF;
        data_available = 1'b1;
        step();
        data_available = 1'b0;
        run_to_done("ignore");
        repeat (4) step();
        check("ignore_no_restart", 64'(busy), 64'd0);
        check_frame_words("ignore", 16'h0002);

        // Back-to-back frames with data_available held high
        pix_gen_data = {$urandom, $urandom};
        seq0 = m_seq;
        idle_run = 0;
        n_done = 0;
        seen_busy = 1'b0;
        data_available = 1'b1;
        pixel_en = 1'b1;
        for (int i = 0; i < 100 && m_seq != seq0 + 16'd3; i++) begin
            step();
            if (frame_done) n_done++;
            if (busy) begin
                if (seen_busy && idle_run > 0) check("b2b_gap", 64'(idle_run), 64'd1);
                idle_run = 0;
                seen_busy = 1'b1;
            end else begin
                idle_run++;
            end
        end
        data_available = 1'b0;
        check("b2b_done_count", 64'(n_done), 64'd3);
        repeat (3) step();
        obs_q.delete();

        // Reset in the middle of the payload, then the next header carries seq 0
        pix_gen_data = 64'h0807060504030201;
        data_available = 1'b1;
        step();
        data_available = 1'b0;
        repeat (4) step();
        async_reset();
        step();
        data_available = 1'b1;
        pixel_en = 1'b1;
        step();
        data_available = 1'b0;
        run_to_done("post_reset");
        step();
        check_frame_words("post_reset", 16'h0000);

        // Random traffic: random payloads, requests and pixel_en gaps
        for (int i = 0; i < 400; i++) begin
            data_available = ($urandom_range(0, 5) == 0);
            pixel_en = ($urandom_range(0, 3) != 0);
            pix_gen_data = {$urandom, $urandom};
            step();
        end
        obs_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
